ip_drr_sched: RTL and testbench

- Deficit-round-robin scheduler that shares one ip_arb_mux output between S_COUNT IP frame sources.
- Sits beside the mux. Drives a one-hot grant that gates each source's s_ip_hdr_valid into the mux.
- Charges each source its ip_length bytes per frame.
- Holds the grant until the mux output completes the frame.

---
 rtl/ip_sched_pkg.sv | 35 +++
 rtl/ip_drr_deficit_bank.sv | 53 +++++
 rtl/ip_drr_sched.sv | 174 +++++++++++++++++
 tb/tb_ip_drr_sched.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ip_sched_pkg.sv
// Shared definitions for the IP frame deficit-round-robin scheduler:
// FSM state encoding, deficit bank operation codes and small helpers.
package ip_sched_pkg;

  // Scheduler FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADD   = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_GRANT = 2'd3;

  // Deficit bank operations, applied to the indexed entry only
  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;
  localparam logic [1:0] OP_CLR  = 2'd3;

  // Unsigned add clamped to max_val; callers zero-extend narrower operands
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) begin
      sat_add = max_val;
    end else begin
      sat_add = sum[31:0];
    end
  endfunction

  // One-hot decode of an index; callers truncate to their source count
  function automatic logic [31:0] onehot(input logic [31:0] idx);
    onehot = 32'd1 << idx;
  endfunction

endpackage

// File: rtl/ip_drr_deficit_bank.sv
// Per-source deficit counters for the DRR scheduler. One operation per
// cycle on the entry selected by idx: saturating add, subtract, or clear.
// The selected entry is also presented combinationally for the FSM compare.
module ip_drr_deficit_bank
  import ip_sched_pkg::*;
#(
  parameter int S_COUNT       = 4,
  parameter int DEFICIT_WIDTH = 18,
  parameter int IDX_WIDTH     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IDX_WIDTH-1:0]     idx,
  input  logic [1:0]               op,
  input  logic [DEFICIT_WIDTH-1:0] operand,
  output logic [DEFICIT_WIDTH-1:0] rd_deficit
);

  // Ceiling of a deficit counter; an add past this value sticks here
  localparam logic [31:0] DEF_MAX = {{(32-DEFICIT_WIDTH){1'b0}}, {DEFICIT_WIDTH{1'b1}}};

  logic [DEFICIT_WIDTH-1:0] deficit_r [S_COUNT];
  logic [DEFICIT_WIDTH-1:0] add_val_s;
  logic [DEFICIT_WIDTH-1:0] sub_val_s;

  assign rd_deficit = deficit_r[idx];

  // Candidate results for the indexed entry; subtraction never underflows
  // because the FSM only subtracts a length it has already compared
  always_comb begin
    add_val_s = DEFICIT_WIDTH'(sat_add({{(32-DEFICIT_WIDTH){1'b0}}, deficit_r[idx]},
                                       {{(32-DEFICIT_WIDTH){1'b0}}, operand},
                                       DEF_MAX));
    sub_val_s = deficit_r[idx] - operand;
  end

  // Counter update: reset clears all entries, otherwise apply op to idx
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < S_COUNT; i++) begin
        deficit_r[i] <= '0;
      end
    end else begin
      case (op)
        OP_ADD:  deficit_r[idx] <= add_val_s;
        OP_SUB:  deficit_r[idx] <= sub_val_s;
        OP_CLR:  deficit_r[idx] <= '0;
        default: deficit_r[idx] <= deficit_r[idx];
      endcase
    end
  end

endmodule

// File: rtl/ip_drr_sched.sv
// Deficit-round-robin grant generator for an ip_arb_mux. Each source earns
// its quantum once per visit and spends ip_length bytes per granted frame.
// The one-hot grant gates s_ip_hdr_valid into the mux and is held until the
// mux output signals the end of the frame.
module ip_drr_sched
  import ip_sched_pkg::*;
#(
  parameter int S_COUNT       = 4,
  parameter int LEN_WIDTH     = 16,
  parameter int DEFICIT_WIDTH = 18
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [S_COUNT-1:0]             req_valid,
  input  logic [S_COUNT*LEN_WIDTH-1:0]   req_length,
  input  logic [S_COUNT*LEN_WIDTH-1:0]   quantum,
  input  logic                           frame_done,
  output logic [S_COUNT-1:0]             grant,
  output logic                           grant_valid,
  output logic [$clog2(S_COUNT)-1:0]     grant_index,
  output logic                           err_unexpected_done
);

  localparam int IW = $clog2(S_COUNT);
  localparam logic [IW-1:0] PTR_LAST = IW'(S_COUNT - 1);
  localparam logic [IW-1:0] PTR_ONE  = IW'(1);

  logic [1:0]               state_r;
  logic [1:0]               state_s;
  logic [IW-1:0]            ptr_r;
  logic [IW-1:0]            ptr_s;
  logic [IW-1:0]            ptr_next_s;
  logic [S_COUNT-1:0]       grant_r;
  logic [S_COUNT-1:0]       grant_s;
  logic                     grant_valid_r;
  logic [IW-1:0]            grant_index_r;
  logic [IW-1:0]            grant_index_s;
  logic                     err_r;

  logic [LEN_WIDTH-1:0]     len_a_s     [S_COUNT];
  logic [LEN_WIDTH-1:0]     quantum_a_s [S_COUNT];
  logic [DEFICIT_WIDTH-1:0] len_ext_s;
  logic [DEFICIT_WIDTH-1:0] quantum_ext_s;
  logic                     req_ptr_s;
  logic                     any_req_s;

  logic [1:0]               bank_op_s;
  logic [DEFICIT_WIDTH-1:0] bank_operand_s;
  logic [DEFICIT_WIDTH-1:0] deficit_ptr_s;

  ip_drr_deficit_bank #(
    .S_COUNT       (S_COUNT),
    .DEFICIT_WIDTH (DEFICIT_WIDTH),
    .IDX_WIDTH     (IW)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .idx        (ptr_r),
    .op         (bank_op_s),
    .operand    (bank_operand_s),
    .rd_deficit (deficit_ptr_s)
  );

  // Unpack per-source fields and select the ones under the pointer
  always_comb begin
    for (int i = 0; i < S_COUNT; i++) begin
      len_a_s[i]     = req_length[i*LEN_WIDTH +: LEN_WIDTH];
      quantum_a_s[i] = quantum[i*LEN_WIDTH +: LEN_WIDTH];
    end
    len_ext_s     = {{(DEFICIT_WIDTH-LEN_WIDTH){1'b0}}, len_a_s[ptr_r]};
    quantum_ext_s = {{(DEFICIT_WIDTH-LEN_WIDTH){1'b0}}, quantum_a_s[ptr_r]};
    req_ptr_s     = req_valid[ptr_r];
    any_req_s     = |req_valid;
    if (ptr_r == PTR_LAST) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = ptr_r + PTR_ONE;
    end
  end

  // Next-state, pointer, grant and deficit-bank command for this cycle
  always_comb begin
    state_s        = state_r;
    ptr_s          = ptr_r;
    grant_s        = grant_r;
    grant_index_s  = grant_index_r;
    bank_op_s      = OP_NONE;
    bank_operand_s = '0;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_s = ST_ADD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADD: begin
        if (req_ptr_s && (quantum_ext_s != '0)) begin
          bank_op_s      = OP_ADD;
          bank_operand_s = quantum_ext_s;
          state_s        = ST_CHECK;
        end else begin
          // Idle or disabled sources forfeit any stored credit
          bank_op_s = OP_CLR;
          ptr_s     = ptr_next_s;
          if (any_req_s) begin
            state_s = ST_ADD;
          end else begin
            state_s = ST_IDLE;
          end
        end
      end
      ST_CHECK: begin
        if (req_ptr_s && (len_ext_s <= deficit_ptr_s)) begin
          bank_op_s      = OP_SUB;
          bank_operand_s = len_ext_s;
          grant_s        = S_COUNT'(onehot({{(32-IW){1'b0}}, ptr_r}));
          grant_index_s  = ptr_r;
          state_s        = ST_GRANT;
        end else if (req_ptr_s) begin
          // Not enough credit yet: keep it for the next round
          ptr_s   = ptr_next_s;
          state_s = ST_ADD;
        end else begin
          bank_op_s = OP_CLR;
          ptr_s     = ptr_next_s;
          if (any_req_s) begin
            state_s = ST_ADD;
          end else begin
            state_s = ST_IDLE;
          end
        end
      end
      ST_GRANT: begin
        if (frame_done) begin
          // Same source gets another look without a fresh quantum
          grant_s = '0;
          state_s = ST_CHECK;
        end else begin
          state_s = ST_GRANT;
        end
      end
      default: begin
        grant_s = '0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // Registered FSM state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      ptr_r         <= '0;
      grant_r       <= '0;
      grant_valid_r <= 1'b0;
      grant_index_r <= '0;
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_s;
      ptr_r         <= ptr_s;
      grant_r       <= grant_s;
      grant_valid_r <= |grant_s;
      grant_index_r <= grant_index_s;
      err_r         <= frame_done && (state_r != ST_GRANT);
    end
  end

  assign grant               = grant_r;
  assign grant_valid         = grant_valid_r;
  assign grant_index         = grant_index_r;
  assign err_unexpected_done = err_r;

endmodule

// File: tb/tb_ip_drr_sched.sv
// Directed bench for ip_drr_sched with S_COUNT=4 and 1500-byte quanta.
module tb_ip_drr_sched;

  localparam int S  = 4;
  localparam int LW = 16;
  localparam int DW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic [S-1:0]  req_valid;
  logic [S*LW-1:0] req_length;
  logic [S*LW-1:0] quantum;
  logic          frame_done;
  logic [S-1:0]  grant;
  logic          grant_valid;
  logic [1:0]    grant_index;
  logic          err_unexpected_done;

  int checks   = 0;
  int failures = 0;

  ip_drr_sched #(.S_COUNT(S), .LEN_WIDTH(LW), .DEFICIT_WIDTH(DW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .req_valid           (req_valid),
    .req_length          (req_length),
    .quantum             (quantum),
    .frame_done          (frame_done),
    .grant               (grant),
    .grant_valid         (grant_valid),
    .grant_index         (grant_index),
    .err_unexpected_done (err_unexpected_done)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_done();
    frame_done = 1'b1;
    tick(1);
    frame_done = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic wait_grant(input string tag);
    int cnt;
    cnt = 0;
    while (grant_valid !== 1'b1 && cnt < 30) begin
      tick(1);
      cnt++;
    end
    check(tag, {31'd0, grant_valid}, 32'd1);
  endtask

  initial begin
    logic [3:0] fair_exp [8];
    int other_grants;
    fair_exp = '{4'b0001, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010, 4'b0010, 4'b0010};

    rst        = 1'b1;
    req_valid  = '0;
    req_length = '0;
    quantum    = {4{16'd1500}};
    frame_done = 1'b0;
    tick(2);
    rst = 1'b0;

    // Reset state
    check("rst_grant", {28'd0, grant}, 32'd0);
    check("rst_gvalid", {31'd0, grant_valid}, 32'd0);
    check("rst_gindex", {30'd0, grant_index}, 32'd0);
    check("rst_err", {31'd0, err_unexpected_done}, 32'd0);
    check("rst_state", {30'd0, dut.state_r}, 32'd0);
    check("rst_ptr", {30'd0, dut.ptr_r}, 32'd0);
    for (int k = 0; k < S; k++) begin
      check("rst_deficit", {14'd0, dut.u_bank.deficit_r[k]}, 32'd0);
    end

    // Single source: 1000 then 400 within one quantum, then a 400 that must wait
    req_length[15:0] = 16'd1000;
    req_valid = 4'b0001;
    tick(2);
    check("s1_early", {28'd0, grant}, 32'd0);
    tick(1);
    check("s1_grant", {28'd0, grant}, 32'd1);
    check("s1_gvalid", {31'd0, grant_valid}, 32'd1);
    check("s1_gindex", {30'd0, grant_index}, 32'd0);
    check("s1_def500", {14'd0, dut.u_bank.deficit_r[0]}, 32'd500);
    req_length[15:0] = 16'd400;
    pulse_done();
    check("s1_drop", {28'd0, grant}, 32'd0);
    check("s1_no_err", {31'd0, err_unexpected_done}, 32'd0);
    tick(1);
    check("s1_regrant", {28'd0, grant}, 32'd1);
    check("s1_def100", {14'd0, dut.u_bank.deficit_r[0]}, 32'd100);
    pulse_done();
    tick(5);
    check("s1_wait_round", {28'd0, grant}, 32'd0);
    tick(1);
    check("s1_next_round", {28'd0, grant}, 32'd1);
    check("s1_def1200", {14'd0, dut.u_bank.deficit_r[0]}, 32'd1200);
    req_valid = '0;
    do_reset();

    // Multi-round: 3000-byte frame on src1
    req_length[31:16] = 16'd3000;
    req_valid = 4'b0010;
    tick(3);
    check("mr_def1500", {14'd0, dut.u_bank.deficit_r[1]}, 32'd1500);
    tick(5);
    check("mr_def3000", {14'd0, dut.u_bank.deficit_r[1]}, 32'd3000);
    check("mr_no_grant", {28'd0, grant}, 32'd0);
    tick(1);
    check("mr_grant", {28'd0, grant}, 32'd2);
    check("mr_gindex", {30'd0, grant_index}, 32'd1);
    check("mr_def0", {14'd0, dut.u_bank.deficit_r[1]}, 32'd0);
    req_valid = '0;
    do_reset();

    // Fairness: src0 1500-byte frames vs src1 500-byte frames
    req_length[15:0]  = 16'd1500;
    req_length[31:16] = 16'd500;
    req_valid = 4'b0011;
    other_grants = 0;
    for (int k = 0; k < 8; k++) begin
      wait_grant("fair_timeout");
      check("fair_seq", {28'd0, grant}, {28'd0, fair_exp[k]});
      if (grant[2] || grant[3]) begin
        other_grants++;
      end else begin
        other_grants = other_grants;
      end
      tick(9);
      pulse_done();
    end
    check("fair_src23", other_grants, 32'd0);
    req_valid = '0;
    do_reset();

    // Disabled source: quantum[2]=0, src2 and src3 requesting 100 bytes
    quantum[47:32]    = 16'd0;
    req_length[47:32] = 16'd100;
    req_length[63:48] = 16'd100;
    req_valid = 4'b1100;
    for (int k = 0; k < 3; k++) begin
      wait_grant("dis_timeout");
      check("dis_grant", {28'd0, grant}, 32'd8);
      check("dis_def2", {14'd0, dut.u_bank.deficit_r[2]}, 32'd0);
      check("dis_def3", {14'd0, dut.u_bank.deficit_r[3]}, 32'd1500 - 32'd100 * (k + 1));
      pulse_done();
    end

    // Reset while granted, then a fresh request
    wait_grant("rg_timeout");
    check("rg_pre", {28'd0, grant}, 32'd8);
    rst = 1'b1;
    req_valid = 4'b0001;
    quantum = {4{16'd1500}};
    req_length[15:0] = 16'd1000;
    tick(1);
    rst = 1'b0;
    check("rg_grant", {28'd0, grant}, 32'd0);
    check("rg_gvalid", {31'd0, grant_valid}, 32'd0);
    check("rg_ptr", {30'd0, dut.ptr_r}, 32'd0);
    for (int k = 0; k < S; k++) begin
      check("rg_deficit", {14'd0, dut.u_bank.deficit_r[k]}, 32'd0);
    end
    tick(2);
    check("rg_early", {28'd0, grant}, 32'd0);
    tick(1);
    check("rg_new", {28'd0, grant}, 32'd1);
    req_valid = '0;
    do_reset();

    // Zero-length frame is granted and charges nothing
    req_length[15:0] = 16'd0;
    req_valid = 4'b0001;
    tick(3);
    check("zl_grant", {28'd0, grant}, 32'd1);
    check("zl_def", {14'd0, dut.u_bank.deficit_r[0]}, 32'd1500);
    req_valid = '0;
    do_reset();

    // Stray frame_done in IDLE
    pulse_done();
    check("stray_err", {31'd0, err_unexpected_done}, 32'd1);
    check("stray_state", {30'd0, dut.state_r}, 32'd0);
    tick(1);
    check("stray_err_clr", {31'd0, err_unexpected_done}, 32'd0);
    check("stray_state2", {30'd0, dut.state_r}, 32'd0);
    check("stray_grant", {28'd0, grant}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
